rx_byte_framer: RTL and testbench
=================================

RX_BYTE_FRAMER -- requirements
Module: rx_byte_framer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: system clocks per USB bit time; SHALL be >= 4.
REQ-002 Parameter SAMPLE_POINT, default 3: timer count at which a bit is sampled; SHALL be < CLKS_PER_BIT.
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 n_rst  in  1  reset, asynchronous, active-low.
REQ-005 d_plus_sync  in  1  D+ line, already synchronized to clk.
REQ-006 d_minus_sync  in  1  D- line, already synchronized to clk.
REQ-007 rcving  in  1  receive-enable from the receiver control unit (OR of its sync/pid/data receiving flags).
REQ-008 d_edge  out  1  transition detected on D+.
REQ-009 eop  out  1  single-ended-zero (EOP) present on the bus.
REQ-010 shift_enable  out  1  one-cycle strobe at each bit sample point.
REQ-011 rcv_data  out  8  last complete decoded byte, LSB-first assembly.
REQ-012 byte_received  out  1  one-cycle pulse; a new byte is valid on rcv_data.

Function
REQ-013 d_plus_prev register SHALL hold D+ from the previous cycle; d_edge SHALL be combinational d_plus_sync XOR d_plus_prev.
REQ-014 eop SHALL be combinational: 1 iff d_plus_sync=0 and d_minus_sync=0.
REQ-015 Bit timer clk_cnt SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 while rcving=1; it SHALL be held at 0 while rcving=0.
REQ-016 On d_edge=1 with rcving=1, clk_cnt SHALL load 0 (resync) regardless of current count.
REQ-017 shift_enable SHALL be 1 iff rcving=1, clk_cnt=SAMPLE_POINT and d_edge=0; resync wins when both coincide.
REQ-018 NRZI decode: at each shift_enable, decoded bit SHALL be 1 if d_plus_sync equals last_level, else 0; last_level SHALL then load d_plus_sync.
REQ-019 last_level SHALL be 1 (idle J) whenever rcving=0.
REQ-020 Unstuffing: ones_cnt (3 bits) SHALL count consecutive decoded 1s; after the sixth 1, the next sampled bit SHALL be discarded (no shift, no bit count) and ones_cnt SHALL clear.
REQ-021 Decoded 0 (not stuffed) SHALL clear ones_cnt.
REQ-022 Shift register SHALL shift right, new bit into bit 7: sr <= {bit, sr[7:1]}.
REQ-023 bit_cnt (0..7) SHALL increment per non-stuffed shift; on the eighth bit it SHALL wrap to 0, rcv_data SHALL load the completed byte, and byte_received SHALL assert for exactly the next cycle.
REQ-024 rcv_data SHALL hold its value between byte_received pulses, including across rcving=0.
REQ-025 If eop=1 at a shift_enable, no shift SHALL occur, bit_cnt and ones_cnt SHALL clear, and byte_received SHALL not assert.
REQ-026 rcving=0 SHALL clear bit_cnt, ones_cnt and sr within one cycle; a partial byte SHALL never produce byte_received.
REQ-027 Latency: byte_received SHALL assert 1 cycle after the shift_enable capturing the eighth bit.

Reset
REQ-028 On n_rst=0: clk_cnt=0, bit_cnt=0, ones_cnt=0, sr=0x00, rcv_data=0x00, byte_received=0, d_plus_prev=1, last_level=1.
REQ-029 With d_plus_sync=1, d_minus_sync=0 and rcving=0 during reset, every output SHALL read 0.
REQ-030 Reset asserted mid-byte SHALL discard the partial byte; no byte_received SHALL follow deassertion.

Verification
REQ-031 Reset with D+=1/D-=0 -> d_edge, eop, shift_enable, byte_received all 0; rcv_data=0x00.
REQ-032 SYNC KJKJKJKK at 8 clk/bit, rcving=1 from first edge -> exactly 8 shift_enable strobes, one byte_received, rcv_data=0x80.
REQ-033 Six decoded 1s, stuffed 0, then two more bits -> stuffed bit dropped; byte_received after the 8th non-stuffed bit, rcv_data upper bits reflect only data bits.
REQ-034 One bit stretched to 9 clocks -> edge resyncs clk_cnt to 0; no missed or duplicated shift_enable; byte value unchanged.
REQ-035 SE0 (D+=D-=0) after 5 bits -> eop=1, no byte_received; next byte assembles from bit 0 correctly.
REQ-036 rcving dropped after 4 bits, re-raised -> no byte_received; last_level=1; next full byte decodes correctly, prior rcv_data held meanwhile.

Source files
------------

// File: rtl/rx_byte_framer_if.sv
// rx_byte_framer_if: bundle between the line front end / receiver control and
// the byte framer.
//   d_plus_sync, d_minus_sync : synchronized D+/D- levels       (master -> slave)
//   rcving                    : receive enable                  (master -> slave)
//   d_edge, eop, shift_enable : combinational line status       (slave -> master)
//   rcv_data, byte_received   : registered byte and valid pulse (slave -> master)
interface rx_byte_framer_if;
    logic       d_plus_sync;
    logic       d_minus_sync;
    logic       rcving;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;
    logic       byte_received;

    modport master (
        output d_plus_sync, d_minus_sync, rcving,
        input  d_edge, eop, shift_enable, rcv_data, byte_received
    );

    modport slave (
        input  d_plus_sync, d_minus_sync, rcving,
        output d_edge, eop, shift_enable, rcv_data, byte_received
    );
endinterface

// File: rtl/rx_byte_framer.sv
// rx_byte_framer: USB receive bit timing, NRZI decode, bit unstuffing and
// LSB-first byte assembly.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : rx_byte_framer_if.slave (line inputs, rcving, decoded byte out)
// CLKS_PER_BIT must be >= 4 and SAMPLE_POINT < CLKS_PER_BIT.
module rx_byte_framer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    rx_byte_framer_if.slave   bus
);
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned ONES_MAX = 6;

    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       r_ones_cnt;
    logic [7:0]       r_sr;
    logic [7:0]       r_rcv_data;
    logic             r_byte_received;
    logic             r_d_plus_prev;
    logic             r_last_level;

    logic             w_d_edge;
    logic             w_eop;
    logic             w_shift_enable;
    logic             w_bit;
    logic [7:0]       w_sr_next;

    // Line status and sample strobe; an edge on the sample count resyncs instead.
    always_comb begin
        w_d_edge       = bus.d_plus_sync ^ r_d_plus_prev;
        w_eop          = ~bus.d_plus_sync & ~bus.d_minus_sync;
        w_shift_enable = bus.rcving && (r_clk_cnt == CNT_W'(SAMPLE_POINT)) && !w_d_edge;
        // NRZI: no change in level decodes as 1
        w_bit          = (bus.d_plus_sync == r_last_level);
        w_sr_next      = {w_bit, r_sr[7:1]};
    end

    assign bus.d_edge        = w_d_edge;
    assign bus.eop           = w_eop;
    assign bus.shift_enable  = w_shift_enable;
    assign bus.rcv_data      = r_rcv_data;
    assign bus.byte_received = r_byte_received;

    // Bit timer, decoder, unstuffer and byte assembly state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_clk_cnt       <= '0;
            r_bit_cnt       <= '0;
            r_ones_cnt      <= '0;
            r_sr            <= '0;
            r_rcv_data      <= '0;
            r_byte_received <= 1'b0;
            r_d_plus_prev   <= 1'b1;
            r_last_level    <= 1'b1;
        end else begin
            r_d_plus_prev   <= bus.d_plus_sync;
            r_byte_received <= 1'b0;
            if (!bus.rcving) begin
                // Idle: drop any partial byte and return to the J reference level
                r_clk_cnt    <= '0;
                r_bit_cnt    <= '0;
                r_ones_cnt   <= '0;
                r_sr         <= '0;
                r_last_level <= 1'b1;
            end else begin
                if (w_d_edge || (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1))) begin
                    r_clk_cnt <= '0;
                end else begin
                    r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                end

                if (w_shift_enable) begin
                    r_last_level <= bus.d_plus_sync;
                    if (w_eop) begin
                        // SE0 aborts the byte in progress
                        r_bit_cnt  <= '0;
                        r_ones_cnt <= '0;
                    end else if (r_ones_cnt == 3'(ONES_MAX)) begin
                        // Stuffed bit after six 1s: discard
                        r_ones_cnt <= '0;
                    end else begin
                        r_sr       <= w_sr_next;
                        r_ones_cnt <= w_bit ? (r_ones_cnt + 3'd1) : 3'd0;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt       <= '0;
                            r_rcv_data      <= w_sr_next;
                            r_byte_received <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_byte_framer.sv
// tb_rx_byte_framer: drives NRZI/bit-stuffed USB line traffic into
// rx_byte_framer and compares received bytes and strobe counts against the
// bytes and line-bit counts produced by a bit-level encoder model.
module tb_rx_byte_framer;
    localparam int CPB = 8;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    rx_byte_framer_if bus ();

    rx_byte_framer #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(3)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // encoder model state
    logic       r_lvl;
    int         ones;
    int         line_bits;
    int         stretch_at = -1;
    logic [7:0] exp_q[$];

    // monitor state
    logic [7:0] got_q[$];
    int         se_cnt;
    int         eop_seen;
    int         lat_err;
    int         dbl_err;
    logic       prev_se = 1'b0;
    logic       prev_br = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_se = 1'b0;
            prev_br = 1'b0;
        end else begin
            if (bus.shift_enable) se_cnt++;
            if (bus.eop) eop_seen++;
            if (bus.byte_received) begin
                got_q.push_back(bus.rcv_data);
                if (!prev_se) lat_err++;
                if (prev_br)  dbl_err++;
            end
            prev_se = bus.shift_enable;
            prev_br = bus.byte_received;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic put(input logic dp, input logic dm, input logic rv, input int n);
        bus.d_plus_sync  = dp;
        bus.d_minus_sync = dm;
        bus.rcving       = rv;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        put(1'b1, 1'b0, 1'b0, n);
    endtask

    task automatic clr();
        got_q.delete();
        exp_q.delete();
        se_cnt = 0; eop_seen = 0; lat_err = 0; dbl_err = 0;
        line_bits = 0; stretch_at = -1;
    endtask

    task automatic start_xfer();
        r_lvl = 1'b1;
        ones  = 0;
    endtask

    task automatic send_line_bit(input logic lvl);
        put(lvl, ~lvl, 1'b1, (line_bits == stretch_at) ? CPB + 1 : CPB);
        r_lvl = lvl;
        line_bits++;
    endtask

    // NRZI encode one logical bit, inserting a stuffed 0 after six 1s
    task automatic send_bit(input logic b);
        send_line_bit(b ? r_lvl : ~r_lvl);
        if (b) begin
            ones++;
            if (ones == 6) begin
                send_line_bit(~r_lvl);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        exp_q.push_back(v);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        put(1'b1, 1'b0, 1'b0, 3);
        n_vec++; if (bus.d_edge !== 1'b0)        begin n_err++; $display("FAIL reset_d_edge got=%b exp=0", bus.d_edge); end
        n_vec++; if (bus.eop !== 1'b0)           begin n_err++; $display("FAIL reset_eop got=%b exp=0", bus.eop); end
        n_vec++; if (bus.shift_enable !== 1'b0)  begin n_err++; $display("FAIL reset_shift_enable got=%b exp=0", bus.shift_enable); end
        n_vec++; if (bus.byte_received !== 1'b0) begin n_err++; $display("FAIL reset_byte_received got=%b exp=0", bus.byte_received); end
        n_vec++; if (bus.rcv_data !== 8'h00)     begin n_err++; $display("FAIL reset_rcv_data got=%h exp=00", bus.rcv_data); end
        n_rst = 1'b1;
        idle(4);
    endtask

    task automatic test_sync();
        clr();
        start_xfer();
        send_byte(8'h80);   // KJKJKJKK
        idle(2 * CPB);
        n_vec++; if (se_cnt !== 8) begin n_err++; $display("FAIL sync_strobes got=%0d exp=8", se_cnt); end
        n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL sync_nbytes got=%0d exp=1", got_q.size()); end
        n_vec++; if (got_q.size() > 0 && got_q[0] !== 8'h80) begin n_err++; $display("FAIL sync_byte got=%h exp=80", got_q[0]); end
        n_vec++; if (lat_err !== 0 || dbl_err !== 0) begin n_err++; $display("FAIL sync_pulse lat=%0d dbl=%0d exp=0/0", lat_err, dbl_err); end
    endtask

    task automatic test_random_bytes();
        for (int t = 0; t < 4; t++) begin
            int nb;
            clr();
            start_xfer();
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < nb; k++) send_byte(8'($urandom));
            idle(2 * CPB);
            n_vec++; if (se_cnt !== line_bits) begin n_err++; $display("FAIL rand_strobes t=%0d got=%0d exp=%0d", t, se_cnt, line_bits); end
            n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_nbytes t=%0d got=%0d exp=%0d", t, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rand_byte t=%0d k=%0d got=%h exp=%h", t, k, got_q[k], exp_q[k]); end
            end
            n_vec++; if (lat_err !== 0 || dbl_err !== 0) begin n_err++; $display("FAIL rand_pulse lat=%0d dbl=%0d exp=0/0", lat_err, dbl_err); end
        end
    endtask

    task automatic test_stuff();
        logic [7:0] v;
        clr();
        start_xfer();
        v = {2'($urandom), 6'h3F};
        send_byte(v);
        idle(2 * CPB);
        n_vec++; if (se_cnt !== 9) begin n_err++; $display("FAIL stuff_strobes got=%0d exp=9", se_cnt); end
        n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL stuff_nbytes got=%0d exp=1", got_q.size()); end
        n_vec++; if (got_q.size() > 0 && got_q[0] !== v) begin n_err++; $display("FAIL stuff_byte got=%h exp=%h", got_q[0], v); end
        // stuffing run carried across a byte boundary
        clr();
        start_xfer();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'($urandom));
        idle(2 * CPB);
        n_vec++; if (se_cnt !== line_bits) begin n_err++; $display("FAIL stuff2_strobes got=%0d exp=%0d", se_cnt, line_bits); end
        n_vec++; if (got_q.size() !== 3) begin n_err++; $display("FAIL stuff2_nbytes got=%0d exp=3", got_q.size()); end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stuff2_byte k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_stretch();
        for (int t = 0; t < 3; t++) begin
            clr();
            start_xfer();
            stretch_at = int'($urandom_range(1, 14));
            send_byte(8'($urandom));
            send_byte(8'($urandom));
            idle(2 * CPB);
            n_vec++; if (se_cnt !== line_bits) begin n_err++; $display("FAIL stretch_strobes at=%0d got=%0d exp=%0d", stretch_at, se_cnt, line_bits); end
            n_vec++; if (got_q.size() !== 2) begin n_err++; $display("FAIL stretch_nbytes got=%0d exp=2", got_q.size()); end
            for (int k = 0; k < 2 && k < got_q.size(); k++) begin
                n_vec++; if (got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL stretch_byte k=%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_eop();
        logic [7:0] v;
        clr();
        start_xfer();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        // SE0 for one bit time; the sampled D+ (0) becomes the NRZI reference
        put(1'b0, 1'b0, 1'b1, CPB);
        line_bits++;
        r_lvl = 1'b0;
        ones  = 0;
        v = 8'($urandom);
        send_byte(v);
        idle(2 * CPB);
        n_vec++; if (eop_seen < CPB) begin n_err++; $display("FAIL eop_flag got=%0d cycles exp>=%0d", eop_seen, CPB); end
        n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL eop_nbytes got=%0d exp=1", got_q.size()); end
        n_vec++; if (got_q.size() > 0 && got_q[0] !== v) begin n_err++; $display("FAIL eop_next_byte got=%h exp=%h", got_q[0], v); end
        n_vec++; if (se_cnt !== line_bits) begin n_err++; $display("FAIL eop_strobes got=%0d exp=%0d", se_cnt, line_bits); end
    endtask

    task automatic test_rcving_drop();
        logic [7:0] a;
        logic [7:0] b;
        clr();
        a = 8'($urandom);
        b = 8'($urandom);
        start_xfer();
        send_byte(a);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        idle(2 * CPB);
        n_vec++; if (bus.rcv_data !== a) begin n_err++; $display("FAIL drop_hold got=%h exp=%h", bus.rcv_data, a); end
        n_vec++; if (got_q.size() !== 1) begin n_err++; $display("FAIL drop_partial got=%0d bytes exp=1", got_q.size()); end
        start_xfer();
        send_byte(b);
        idle(2 * CPB);
        n_vec++; if (got_q.size() !== 2) begin n_err++; $display("FAIL drop_nbytes got=%0d exp=2", got_q.size()); end
        n_vec++; if (got_q.size() > 1 && got_q[1] !== b) begin n_err++; $display("FAIL drop_next_byte got=%h exp=%h", got_q[1], b); end
    endtask

    task automatic test_reset_mid();
        clr();
        start_xfer();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        n_rst = 1'b0;
        put(1'b1, 1'b0, 1'b0, 3);
        n_rst = 1'b1;
        idle(3 * CPB);
        n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL rstmid_nbytes got=%0d exp=0", got_q.size()); end
        n_vec++; if (bus.rcv_data !== 8'h00) begin n_err++; $display("FAIL rstmid_rcv_data got=%h exp=00", bus.rcv_data); end
        // decoder is usable after the mid-byte reset
        clr();
        start_xfer();
        send_byte(8'h5A);
        idle(2 * CPB);
        n_vec++; if (got_q.size() !== 1 || got_q[0] !== 8'h5A) begin n_err++; $display("FAIL rstmid_after nbytes=%0d exp=1 byte exp=5a", got_q.size()); end
    endtask

    initial begin
        bus.d_plus_sync  = 1'b1;
        bus.d_minus_sync = 1'b0;
        bus.rcving       = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_sync();
        test_random_bytes();
        test_stuff();
        test_stretch();
        test_eop();
        test_rcving_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
